// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order commit: dispatch allocates at tail, writeback marks complete, head retires.
// Optional ROB_PERF_CNT_EN adds retire_count / stall_count performance counters.
module rob_commit_unit #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned PREG_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [PREG_W-1:0] alloc_pd_new,
  input  logic [PREG_W-1:0] alloc_pd_old,
  input  logic [31:0]       alloc_pc,
  output logic [IDX_W-1:0]  alloc_rob_index,
  input  logic              cmpl_valid,
  input  logic [IDX_W-1:0]  cmpl_rob_index,
  output logic              retire_valid,
  input  logic              retire_ready,
  output logic [PREG_W-1:0] retire_pd_new,
  output logic [PREG_W-1:0] retire_pd_old,
  output logic [31:0]       retire_pc,
  output logic [IDX_W-1:0]  retire_rob_index,
  output logic [IDX_W:0]    count,
  output logic              full,
  output logic              empty
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]       retire_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [31:0]       pc;
  } rob_payload_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] complete_q, complete_d;
  rob_payload_t     payload_q [DEPTH];
  rob_payload_t     payload_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic alloc_fire;
  logic retire_fire;

  // Status and head-entry view, all derived from registered state
  always_comb begin
    full             = (count_q == CNT_W'(DEPTH));
    empty            = (count_q == '0);
    count            = count_q;
    alloc_ready      = !full;
    alloc_rob_index  = tail_q;
    retire_rob_index = head_q;
    retire_valid     = valid_q[head_q] && complete_q[head_q];
    retire_pd_new    = payload_q[head_q].pd_new;
    retire_pd_old    = payload_q[head_q].pd_old;
    retire_pc        = payload_q[head_q].pc;
    alloc_fire       = alloc_valid && alloc_ready;
    retire_fire      = retire_valid && retire_ready;
  end

  // Next state: flush dominates; completion is applied before retire/alloc so they override it
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    payload_d  = payload_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush) begin
      valid_d    = '0;
      complete_d = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (cmpl_valid && valid_q[cmpl_rob_index]) begin
        complete_d[cmpl_rob_index] = 1'b1;
      end
      if (retire_fire) begin
        valid_d[head_q]    = 1'b0;
        complete_d[head_q] = 1'b0;
        head_d             = head_q + IDX_W'(1);
      end
      if (alloc_fire) begin
        valid_d[tail_q]          = 1'b1;
        complete_d[tail_q]       = 1'b0;
        payload_d[tail_q].pd_new = alloc_pd_new;
        payload_d[tail_q].pd_old = alloc_pd_old;
        payload_d[tail_q].pc     = alloc_pc;
        tail_d                   = tail_q + IDX_W'(1);
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      complete_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        payload_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      complete_q <= complete_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        payload_q[i] <= payload_d[i];
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] retire_count_q, retire_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Counters survive flush; a retire in the flush cycle is discarded and not counted
  always_comb begin
    retire_count_d = retire_count_q;
    stall_count_d  = stall_count_q;
    if (retire_fire && !flush) begin
      retire_count_d = retire_count_q + 32'd1;
    end
    if (!empty && !retire_valid) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      retire_count_q <= retire_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign retire_count = retire_count_q;
  assign stall_count  = stall_count_q;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed scenarios plus random traffic vs a queue-based model.
// Build with ROB_PERF_CNT_EN defined to also check the performance counters.
module tb_rob_commit_unit;

  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int PREG_W = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              alloc_valid = 1'b0;
  logic              alloc_ready;
  logic [PREG_W-1:0] alloc_pd_new = '0;
  logic [PREG_W-1:0] alloc_pd_old = '0;
  logic [31:0]       alloc_pc = '0;
  logic [IDX_W-1:0]  alloc_rob_index;
  logic              cmpl_valid = 1'b0;
  logic [IDX_W-1:0]  cmpl_rob_index = '0;
  logic              retire_valid;
  logic              retire_ready = 1'b0;
  logic [PREG_W-1:0] retire_pd_new;
  logic [PREG_W-1:0] retire_pd_old;
  logic [31:0]       retire_pc;
  logic [IDX_W-1:0]  retire_rob_index;
  logic [IDX_W:0]    count;
  logic              full;
  logic              empty;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]       retire_count;
  logic [31:0]       stall_count;
`endif

  rob_commit_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_pd_new     (alloc_pd_new),
    .alloc_pd_old     (alloc_pd_old),
    .alloc_pc         (alloc_pc),
    .alloc_rob_index  (alloc_rob_index),
    .cmpl_valid       (cmpl_valid),
    .cmpl_rob_index   (cmpl_rob_index),
    .retire_valid     (retire_valid),
    .retire_ready     (retire_ready),
    .retire_pd_new    (retire_pd_new),
    .retire_pd_old    (retire_pd_old),
    .retire_pc        (retire_pc),
    .retire_rob_index (retire_rob_index),
    .count            (count),
    .full             (full),
    .empty            (empty)
`ifdef ROB_PERF_CNT_EN
    ,
    .retire_count     (retire_count),
    .stall_count      (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: program-ordered queue of in-flight instructions; element k lives at ROB index head+k
  typedef struct {
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [31:0]       pc;
    bit                done;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;
  int   m_retired = 0;
  int   m_stalls = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_head    = 0;
    m_retired = 0;
    m_stalls  = 0;
  endtask

  // Check outputs mid-cycle, then advance the model across the next rising edge
  task automatic step();
    int   sz;
    int   off;
    bit   rv;
    ent_t e;
    @(negedge clk);
    sz = q.size();
    rv = (sz > 0) && q[0].done;
    check("count",        64'(count),            64'(sz));
    check("empty",        64'(empty),            64'(sz == 0));
    check("full",         64'(full),             64'(sz == DEPTH));
    check("alloc_ready",  64'(alloc_ready),      64'(sz < DEPTH));
    check("alloc_index",  64'(alloc_rob_index),  64'((m_head + sz) % DEPTH));
    check("retire_index", 64'(retire_rob_index), 64'(m_head));
    check("retire_valid", 64'(retire_valid),     64'(rv));
    if (rv) begin
      check("retire_pd_new", 64'(retire_pd_new), 64'(q[0].pd_new));
      check("retire_pd_old", 64'(retire_pd_old), 64'(q[0].pd_old));
      check("retire_pc",     64'(retire_pc),     64'(q[0].pc));
    end
`ifdef ROB_PERF_CNT_EN
    check("retire_count", 64'(retire_count), 64'(32'(m_retired)));
    check("stall_count",  64'(stall_count),  64'(32'(m_stalls)));
`endif
    @(posedge clk);
    if (sz > 0 && !rv) m_stalls++;
    if (flush) begin
      q.delete();
      m_head = 0;
    end else begin
      if (cmpl_valid) begin
        off = (int'(cmpl_rob_index) - m_head + DEPTH) % DEPTH;
        if (off < sz) begin
          e      = q[off];
          e.done = 1'b1;
          q[off] = e;
        end
      end
      if (rv && retire_ready) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % DEPTH;
        m_retired++;
      end
      if (alloc_valid && sz < DEPTH) begin
        e.pd_new = alloc_pd_new;
        e.pd_old = alloc_pd_old;
        e.pc     = alloc_pc;
        e.done   = 1'b0;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic drv(input bit av, input int pdn, input int pdo, input int pcv,
                     input bit cv, input int ci, input bit rr, input bit fl);
    alloc_valid    = av;
    alloc_pd_new   = PREG_W'(pdn);
    alloc_pd_old   = PREG_W'(pdo);
    alloc_pc       = 32'(pcv);
    cmpl_valid     = cv;
    cmpl_rob_index = IDX_W'(ci);
    retire_ready   = rr;
    flush          = fl;
    step();
  endtask

  task automatic idle(input bit rr);
    drv(1'b0, 0, 0, 0, 1'b0, 0, rr, 1'b0);
  endtask

  task automatic async_reset_check(input string tag);
    #1;
    rst_n = 1'b0;
    #1;
    check({tag, "_count"},        64'(count),            64'(0));
    check({tag, "_empty"},        64'(empty),            64'(1));
    check({tag, "_full"},         64'(full),             64'(0));
    check({tag, "_alloc_ready"},  64'(alloc_ready),      64'(1));
    check({tag, "_retire_valid"}, 64'(retire_valid),     64'(0));
    check({tag, "_alloc_index"},  64'(alloc_rob_index),  64'(0));
    check({tag, "_retire_index"}, 64'(retire_rob_index), 64'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int sz;
    int ci;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b0);

    // Three allocs, then out-of-order completion and in-order retire
    for (int i = 0; i < 3; i++) drv(1'b1, 40 + i, 1 + i, 'h100 + 4 * i, 1'b0, 0, 1'b0, 1'b0);
    drv(1'b0, 0, 0, 0, 1'b1, 2, 1'b1, 1'b0);
    drv(1'b0, 0, 0, 0, 1'b1, 0, 1'b1, 1'b0);
    repeat (2) idle(1'b1);
    drv(1'b0, 0, 0, 0, 1'b1, 1, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Fill to full, over-alloc, then retire with a simultaneous alloc request
    for (int i = 0; i < DEPTH + 1; i++) drv(1'b1, i, i + 64, 'h200 + i, 1'b0, 0, 1'b0, 1'b0);
    drv(1'b1, 9, 9, 'h999, 1'b1, m_head, 1'b0, 1'b0);
    drv(1'b1, 10, 10, 'hAAA, 1'b0, 0, 1'b1, 1'b0);
    drv(1'b1, 11, 11, 'hBBB, 1'b0, 0, 1'b0, 1'b0);

    // Back-pressure on a complete head, then release for one retire
    drv(1'b0, 0, 0, 0, 1'b1, m_head, 1'b0, 1'b0);
    repeat (4) idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Flush together with alloc and completion; stale completion afterwards
    drv(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drv(1'b1, 20 + i, 30 + i, 'h300 + i, 1'b0, 0, 1'b0, 1'b0);
    drv(1'b0, 0, 0, 0, 1'b1, 1, 1'b0, 1'b0);
    drv(1'b0, 0, 0, 0, 1'b1, 2, 1'b0, 1'b0);
    drv(1'b1, 5, 5, 'h5, 1'b1, 3, 1'b1, 1'b1);
    drv(1'b0, 0, 0, 0, 1'b1, 3, 1'b1, 1'b0);
    repeat (2) idle(1'b1);

    // Async reset mid-stream with 7 entries
    for (int i = 0; i < 7; i++) drv(1'b1, i, i, i, 1'b1, (m_head + i) % DEPTH, 1'b0, 1'b0);
    async_reset_check("arst");
    idle(1'b1);

    // Ten retires plus three head-incomplete cycles for the perf counters
    for (int i = 0; i < 10; i++) drv(1'b1, i, i, i, 1'b0, 0, 1'b0, 1'b0);
    repeat (3) idle(1'b1);
    for (int i = 0; i < 10; i++) drv(1'b0, 0, 0, 0, 1'b1, i, 1'b1, 1'b0);
    repeat (3) idle(1'b1);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      sz = q.size();
      if (sz > 0 && $urandom_range(0, 3) != 0) ci = (m_head + int'($urandom_range(0, sz - 1))) % DEPTH;
      else ci = int'($urandom_range(0, DEPTH - 1));
      drv($urandom_range(0, 9) < 6, int'($urandom), int'($urandom), int'($urandom),
          $urandom_range(0, 1) == 1, ci, $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 2);
    end

    async_reset_check("arst_end");
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
